// File: rtl/s3_writeback_control.sv
// rtl/s3_writeback_control.sv - stage-3 writeback, load wait FSM and core counters
module s3_writeback_control #(
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_s2,
  input  logic [31:0] alu_result_s2,
  input  logic [31:0] pc_s2,
  input  logic        kill_s2,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic [31:0] instruction_s3,
  output logic [31:0] wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        stall,
  output logic        bus_err,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic [7:0]  timer, timer_next;
  logic [31:0] alu_s3, pc_s3;
  logic        valid_s3;
  logic [6:0]  opcode_s3;
  logic [2:0]  funct3_s3;
  logic        load_s3, timeout, writes_rd, load_accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  assign opcode_s3 = instruction_s3[6:0];
  assign funct3_s3 = instruction_s3[14:12];
  assign rf_waddr  = instruction_s3[11:7];
  assign load_s3   = valid_s3 && (opcode_s3 == OP_LOAD);
  // The load has already waited the full budget and data still has not come back.
  assign timeout   = load_s3 && !dmem_rvalid && (state == WAIT) && (timer == TIMEOUT_LIMIT);
  assign load_accept = dmem_rvalid || timeout;

  // Load wait FSM: next state, wait timer and the front-end stall.
  always_comb begin
    state_next = state;
    timer_next = timer;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (load_s3 && !dmem_rvalid) begin
          stall      = 1'b1;
          state_next = WAIT;
          timer_next = 8'd1;
        end
      end
      WAIT: begin
        if (!load_s3 || load_accept) begin
          state_next = IDLE;
          timer_next = 8'd0;
        end else begin
          stall      = 1'b1;
          timer_next = timer + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = 8'd0;
      end
    endcase
  end

  // FSM state and wait timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= 8'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Stage-3 pipeline registers; a kill turns the captured slot into a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_s3 <= NOP_INST;
      alu_s3         <= 32'd0;
      pc_s3          <= 32'd0;
      valid_s3       <= 1'b0;
    end else if (!stall) begin
      instruction_s3 <= kill_s2 ? NOP_INST : instruction_s2;
      alu_s3         <= alu_result_s2;
      pc_s3          <= pc_s2;
      valid_s3       <= !kill_s2;
    end
  end

  // Byte/half lane selection and extension of the returned load word.
  always_comb begin
    load_value = dmem_rdata;
    case (alu_s3[1:0])
      2'd0:    load_byte = dmem_rdata[7:0];
      2'd1:    load_byte = dmem_rdata[15:8];
      2'd2:    load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = alu_s3[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_s3)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'd0, load_byte};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = dmem_rdata;
    endcase
    if (timeout) load_value = 32'd0;
  end

  // Writeback source select and register-file write enable.
  always_comb begin
    wb_data   = alu_s3;
    writes_rd = 1'b0;
    case (opcode_s3)
      OP_LOAD: begin
        wb_data   = load_value;
        writes_rd = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        wb_data   = pc_s3 + 32'd4;
        writes_rd = 1'b1;
      end
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
    rf_we = valid_s3 && writes_rd && (rf_waddr != 5'd0) && (!load_s3 || load_accept);
  end

  // Sticky bus error plus free-running cycle and retired-instruction counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err       <= 1'b0;
      cycle_count   <= 32'd0;
      instret_count <= 32'd0;
    end else begin
      if (timeout) bus_err <= 1'b1;
      cycle_count <= cycle_count + 32'd1;
      if (valid_s3 && !stall) instret_count <= instret_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_s3_writeback_control.sv
// tb/tb_s3_writeback_control.sv - self-checking bench for s3_writeback_control
module tb_s3_writeback_control;

  localparam int          MEM_T = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction_s2 = NOP, alu_result_s2 = '0, pc_s2 = '0, dmem_rdata = '0;
  logic        kill_s2 = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] instruction_s3, wb_data, cycle_count, instret_count;
  logic        rf_we, stall, bus_err;
  logic [4:0]  rf_waddr;

  int errors = 0;
  int checks = 0;

  s3_writeback_control #(.NOP_INST(NOP), .MEM_TIMEOUT(MEM_T)) dut (
    .clk(clk), .rst(rst), .instruction_s2(instruction_s2), .alu_result_s2(alu_result_s2),
    .pc_s2(pc_s2), .kill_s2(kill_s2), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .instruction_s3(instruction_s3), .wb_data(wb_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall(stall), .bus_err(bus_err), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  // Reference model: what sits in stage 3 and how long its load has been waiting.
  logic [31:0] m_inst, m_alu, m_pc, m_cycle, m_instret;
  logic        m_valid, m_bus_err;
  int          m_wait;
  logic        e_stall, e_we, e_timeout;
  logic [31:0] e_wb;

  function automatic logic is_writer(logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6F};
  endfunction

  function automatic logic [31:0] model_wb(logic [31:0] inst, logic [31:0] alu,
                                           logic [31:0] pc, logic [31:0] rd_word, logic to);
    logic [31:0] b, h;
    b = rd_word >> (int'(alu[1:0]) * 8);
    h = rd_word >> (int'(alu[1]) * 16);
    if (inst[6:0] == 7'h03) begin
      if (to) return 32'd0;
      case (inst[14:12])
        3'd0: return {{24{b[7]}}, b[7:0]};
        3'd4: return {24'd0, b[7:0]};
        3'd1: return {{16{h[15]}}, h[15:0]};
        3'd5: return {16'd0, h[15:0]};
        default: return rd_word;
      endcase
    end
    if (inst[6:0] == 7'h6F || inst[6:0] == 7'h67) return pc + 32'd4;
    return alu;
  endfunction

  task automatic model_reset();
    m_inst = NOP; m_alu = 0; m_pc = 0; m_valid = 0; m_wait = 0;
    m_bus_err = 0; m_cycle = 0; m_instret = 0;
  endtask

  task automatic model_eval();
    logic ld;
    ld        = m_valid && (m_inst[6:0] == 7'h03);
    e_timeout = ld && !dmem_rvalid && (m_wait == MEM_T);
    e_stall   = ld && !dmem_rvalid && !e_timeout;
    e_we      = m_valid && is_writer(m_inst[6:0]) && (m_inst[11:7] != 0) &&
                (!ld || dmem_rvalid || e_timeout);
    e_wb      = model_wb(m_inst, m_alu, m_pc, dmem_rdata, e_timeout);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      m_cycle++;
      if (m_valid && !e_stall) m_instret++;
      if (e_timeout) m_bus_err = 1;
      m_wait = e_stall ? m_wait + 1 : 0;
      if (!e_stall) begin
        m_inst = kill_s2 ? NOP : instruction_s2;
        m_alu = alu_result_s2; m_pc = pc_s2; m_valid = !kill_s2;
      end
    end
    #1;
  endtask

  task automatic drive(logic [31:0] inst, logic [31:0] alu, logic [31:0] pc, logic kill);
    instruction_s2 = inst; alu_result_s2 = alu; pc_s2 = pc; kill_s2 = kill;
  endtask

  task automatic test_reset();
    rst = 0; model_reset();
    drive(32'h0070_0293, 32'd7, 32'h100, 0);
    tick(); tick(); settle();
    checks += 7;
    if (instruction_s3 !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", instruction_s3, NOP); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb got=%h exp=0", wb_data); end
    if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_buserr got=%b exp=0", bus_err); end
    if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", cycle_count); end
    if (instret_count !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret_count); end
  endtask

  task automatic test_addi();
    rst = 1;
    tick();
    drive(NOP, 32'd0, 32'd0, 1);
    settle();
    checks += 4;
    if (rf_we !== 1'b1) begin errors++; $display("FAIL addi_we got=%b exp=1", rf_we); end
    if (rf_waddr !== 5'd5) begin errors++; $display("FAIL addi_waddr got=%0d exp=5", rf_waddr); end
    if (wb_data !== 32'd7) begin errors++; $display("FAIL addi_wb got=%h exp=7", wb_data); end
    if (instret_count !== 32'd0) begin errors++; $display("FAIL addi_instret0 got=%0d exp=0", instret_count); end
    tick();
    checks += 2;
    if (instret_count !== 32'd1) begin errors++; $display("FAIL addi_instret got=%0d exp=1", instret_count); end
    if (cycle_count !== 32'd2) begin errors++; $display("FAIL addi_cycle got=%0d exp=2", cycle_count); end
  endtask

  task automatic test_load_extract();
    dmem_rvalid = 0;
    drive(32'h0000_0303, 32'h0000_1003, 32'h200, 0);
    tick();
    dmem_rdata = 32'h80FF_FF12; dmem_rvalid = 1;
    drive(32'h0000_5383, 32'h0000_1002, 32'h204, 0);
    settle();
    checks += 3;
    if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb got=%h exp=ffffff80", wb_data); end
    if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall got=%b exp=0", stall); end
    if (rf_we !== 1'b1) begin errors++; $display("FAIL lb_we got=%b exp=1", rf_we); end
    tick();
    drive(NOP, 0, 0, 1);
    settle();
    checks += 2;
    if (wb_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_wb got=%h exp=000080ff", wb_data); end
    if (rf_waddr !== 5'd7) begin errors++; $display("FAIL lhu_waddr got=%0d exp=7", rf_waddr); end
  endtask

  task automatic test_stall();
    logic [31:0] i0;
    dmem_rvalid = 1;
    drive(32'h0000_2403, 32'h0000_2000, 32'h300, 0);
    tick();
    i0 = m_instret;
    dmem_rvalid = 0; dmem_rdata = 32'hDEAD_BEEF;
    drive(32'h0010_0493, 32'd1, 32'h304, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checks += 4;
      if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall[%0d] got=%b exp=1", i, stall); end
      if (rf_we !== 1'b0) begin errors++; $display("FAIL lw_we_held[%0d] got=%b exp=0", i, rf_we); end
      if (instruction_s3 !== 32'h0000_2403) begin errors++; $display("FAIL lw_hold[%0d] got=%h exp=00002403", i, instruction_s3); end
      if (instret_count !== i0) begin errors++; $display("FAIL lw_instret_held[%0d] got=%0d exp=%0d", i, instret_count, i0); end
      tick();
    end
    dmem_rvalid = 1;
    settle();
    checks += 3;
    if (stall !== 1'b0) begin errors++; $display("FAIL lw_release got=%b exp=0", stall); end
    if (rf_we !== 1'b1) begin errors++; $display("FAIL lw_we got=%b exp=1", rf_we); end
    if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wb got=%h exp=deadbeef", wb_data); end
    tick();
    checks += 2;
    if (instret_count !== i0 + 32'd1) begin errors++; $display("FAIL lw_instret got=%0d exp=%0d", instret_count, i0 + 1); end
    if (instruction_s3 !== 32'h0010_0493) begin errors++; $display("FAIL lw_next got=%h exp=00100493", instruction_s3); end
  endtask

  task automatic test_timeout();
    int n;
    logic done;
    dmem_rvalid = 1;
    drive(32'h0000_2503, 32'h0000_3000, 32'h400, 0);
    tick();
    dmem_rvalid = 0;
    drive(32'h0030_0593, 32'd3, 32'h404, 0);
    n = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      settle();
      if (stall === 1'b1) begin n++; tick(); end
      else done = 1;
    end
    checks += 3;
    if (n != MEM_T) begin errors++; $display("FAIL to_stall_cycles got=%0d exp=%0d", n, MEM_T); end
    if (rf_we !== 1'b1) begin errors++; $display("FAIL to_we got=%b exp=1", rf_we); end
    if (wb_data !== 32'd0) begin errors++; $display("FAIL to_wb got=%h exp=0", wb_data); end
    tick();
    drive(NOP, 0, 0, 1);
    settle();
    checks += 3;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL to_buserr got=%b exp=1", bus_err); end
    if (instruction_s3 !== 32'h0030_0593) begin errors++; $display("FAIL to_next got=%h exp=00300593", instruction_s3); end
    if (wb_data !== 32'd3) begin errors++; $display("FAIL to_next_wb got=%h exp=3", wb_data); end
    tick(); tick();
    checks += 1;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", bus_err); end
  endtask

  task automatic test_jal_kill();
    logic [31:0] i0;
    dmem_rvalid = 0;
    drive(32'h0000_00EF, 32'h1234, 32'hFFFF_FFFC, 0);
    tick();
    drive(32'h0050_0013, 32'd5, 32'h0, 0);
    settle();
    checks += 2;
    if (wb_data !== 32'd0) begin errors++; $display("FAIL jal_wb got=%h exp=0", wb_data); end
    if (rf_we !== 1'b1) begin errors++; $display("FAIL jal_we got=%b exp=1", rf_we); end
    tick();
    drive(32'h0050_0293, 32'd5, 32'h4, 1);
    settle();
    checks += 1;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got=%b exp=0", rf_we); end
    tick();
    i0 = m_instret;
    drive(NOP, 0, 0, 1);
    settle();
    checks += 2;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL kill_we got=%b exp=0", rf_we); end
    if (instruction_s3 !== NOP) begin errors++; $display("FAIL kill_inst got=%h exp=%h", instruction_s3, NOP); end
    tick();
    checks += 1;
    if (instret_count !== i0) begin errors++; $display("FAIL kill_instret got=%0d exp=%0d", instret_count, i0); end
  endtask

  task automatic test_reset_mid_wait();
    dmem_rvalid = 0;
    drive(32'h0000_2603, 32'h0000_5000, 32'h500, 0);
    tick(); tick();
    settle();
    checks += 1;
    if (stall !== 1'b1) begin errors++; $display("FAIL rmw_wait got=%b exp=1", stall); end
    rst = 0; model_reset();
    #1;
    checks += 4;
    if (stall !== 1'b0) begin errors++; $display("FAIL rmw_stall got=%b exp=0", stall); end
    if (instruction_s3 !== NOP) begin errors++; $display("FAIL rmw_inst got=%h exp=%h", instruction_s3, NOP); end
    if (cycle_count !== 32'd0) begin errors++; $display("FAIL rmw_cycle got=%0d exp=0", cycle_count); end
    if (bus_err !== 1'b0) begin errors++; $display("FAIL rmw_buserr got=%b exp=0", bus_err); end
    tick();
    rst = 1; dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA;
    drive(NOP, 0, 0, 1);
    settle();
    checks += 2;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rmw_late_we got=%b exp=0", rf_we); end
    if (stall !== 1'b0) begin errors++; $display("FAIL rmw_late_stall got=%b exp=0", stall); end
    tick();
    checks += 2;
    if (cycle_count !== 32'd1) begin errors++; $display("FAIL rmw_restart got=%0d exp=1", cycle_count); end
    if (instret_count !== 32'd0) begin errors++; $display("FAIL rmw_instret got=%0d exp=0", instret_count); end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    logic [2:0]  f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0]  ops [7] = '{7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h23, 7'h73};
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k < 3) begin v[6:0] = 7'h03; v[14:12] = f3s[$urandom_range(0, 4)]; end
    else v[6:0] = ops[k - 3];
    if ($urandom_range(0, 7) == 0) v[11:7] = 5'd0;
    return v;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(rand_inst(), $urandom, $urandom, ($urandom_range(0, 6) == 0));
      dmem_rdata = $urandom;
      dmem_rvalid = ($urandom_range(0, 9) < 4);
      settle();
      checks += 7;
      if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
      if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, rf_we, e_we); end
      if (e_we && wb_data !== e_wb) begin errors++; $display("FAIL rnd_wb c=%0d got=%h exp=%h", c, wb_data, e_wb); end
      if (instruction_s3 !== m_inst || rf_waddr !== m_inst[11:7]) begin errors++; $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, instruction_s3, m_inst); end
      if (bus_err !== m_bus_err) begin errors++; $display("FAIL rnd_buserr c=%0d got=%b exp=%b", c, bus_err, m_bus_err); end
      if (cycle_count !== m_cycle) begin errors++; $display("FAIL rnd_cycle c=%0d got=%0d exp=%0d", c, cycle_count, m_cycle); end
      if (instret_count !== m_instret) begin errors++; $display("FAIL rnd_instret c=%0d got=%0d exp=%0d", c, instret_count, m_instret); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_load_extract();
    test_stall();
    test_timeout();
    test_jal_kill();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
